// File: rtl/lfsr_stats_pkg.sv
// Shared widths and the saturating-increment rule used by the LFSR statistics counters.
package lfsr_stats_pkg;

  localparam int CNT_W_DEFAULT = 13;
  localparam int RUN_W_DEFAULT = 13;

  // Increment within the low `width` bits; the all-ones value holds instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_stats_counter_run_tracker.sv
// Longest-run tracker for a sampled bit stream; outputs already include the current cycle's
// sample so the parent can capture period results on the same edge that clears this state.
module run_tracker
  import lfsr_stats_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             sample_bit,
  input  logic             clear,
  output logic [RUN_W-1:0] max_run1,
  output logic [RUN_W-1:0] max_run0,
  output logic             sat
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic             last_bit_reg;
  logic             last_bit_next;
  logic             run_active_reg;
  logic             run_active_next;
  logic [RUN_W-1:0] cur_run_reg;
  logic [RUN_W-1:0] cur_run_next;
  logic [RUN_W-1:0] max_run1_reg;
  logic [RUN_W-1:0] max_run1_next;
  logic [RUN_W-1:0] max_run0_reg;
  logic [RUN_W-1:0] max_run0_next;

  always_comb begin
    last_bit_next   = last_bit_reg;
    run_active_next = run_active_reg;
    cur_run_next    = cur_run_reg;
    max_run1_next   = max_run1_reg;
    max_run0_next   = max_run0_reg;
    if (sample) begin
      last_bit_next   = sample_bit;
      run_active_next = 1'b1;
      if (run_active_reg && (sample_bit == last_bit_reg)) begin
        cur_run_next = RUN_W'(sat_inc(32'(cur_run_reg), RUN_W));
      end else begin
        cur_run_next = RUN_W'(1);
      end
      if (sample_bit && (cur_run_next > max_run1_reg)) begin
        max_run1_next = cur_run_next;
      end
      if (!sample_bit && (cur_run_next > max_run0_reg)) begin
        max_run0_next = cur_run_next;
      end
    end
  end

  assign max_run1 = max_run1_next;
  assign max_run0 = max_run0_next;
  // Only a fresh sample can push the run to all-ones; the parent keeps the sticky flag.
  assign sat      = sample && (cur_run_next == RUN_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      last_bit_reg   <= 1'b0;
      run_active_reg <= 1'b0;
      cur_run_reg    <= '0;
      max_run1_reg   <= '0;
      max_run0_reg   <= '0;
    end else begin
      last_bit_reg   <= last_bit_next;
      run_active_reg <= run_active_next;
      cur_run_reg    <= cur_run_next;
      max_run1_reg   <= max_run1_next;
      max_run0_reg   <= max_run0_next;
    end
  end

endmodule

// File: rtl/lfsr_stats_counter.sv
// Per-period ones/zeros/longest-run statistics for an LFSR output bit, with a single-entry
// result register handed to a consumer via valid/ack and a sticky overrun flag.
module lfsr_stats_counter
  import lfsr_stats_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int RUN_W = RUN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_in,
  input  logic             max_tick,
  input  logic             res_ack,
  output logic [CNT_W-1:0] ones_count,
  output logic [CNT_W-1:0] zeros_count,
  output logic [CNT_W-1:0] res_ones,
  output logic [CNT_W-1:0] res_zeros,
  output logic [RUN_W-1:0] res_run1,
  output logic [RUN_W-1:0] res_run0,
  output logic             res_sat,
  output logic             res_valid,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] ones_reg;
  logic [CNT_W-1:0] ones_next;
  logic [CNT_W-1:0] zeros_reg;
  logic [CNT_W-1:0] zeros_next;
  logic             sat_reg;
  logic             sat_next;
  logic [RUN_W-1:0] run1_next;
  logic [RUN_W-1:0] run0_next;
  logic             run_sat;

  logic [CNT_W-1:0] res_ones_reg;
  logic [CNT_W-1:0] res_zeros_reg;
  logic [RUN_W-1:0] res_run1_reg;
  logic [RUN_W-1:0] res_run0_reg;
  logic             res_sat_reg;
  logic             res_valid_reg;
  logic             overrun_reg;

  run_tracker #(
    .RUN_W(RUN_W)
  ) u_run_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (en),
    .sample_bit(bit_in),
    .clear     (max_tick),
    .max_run1  (run1_next),
    .max_run0  (run0_next),
    .sat       (run_sat)
  );

  always_comb begin
    ones_next  = ones_reg;
    zeros_next = zeros_reg;
    if (en) begin
      if (bit_in) begin
        ones_next = CNT_W'(sat_inc(32'(ones_reg), CNT_W));
      end else begin
        zeros_next = CNT_W'(sat_inc(32'(zeros_reg), CNT_W));
      end
    end
    sat_next = sat_reg || run_sat || (ones_next == CNT_MAX) || (zeros_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_reg      <= '0;
      zeros_reg     <= '0;
      sat_reg       <= 1'b0;
      res_ones_reg  <= '0;
      res_zeros_reg <= '0;
      res_run1_reg  <= '0;
      res_run0_reg  <= '0;
      res_sat_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (max_tick) begin
        ones_reg  <= '0;
        zeros_reg <= '0;
        sat_reg   <= 1'b0;
      end else begin
        ones_reg  <= ones_next;
        zeros_reg <= zeros_next;
        sat_reg   <= sat_next;
      end

      // An ack in the same cycle frees the slot, so the new period result replaces the old one.
      if (max_tick) begin
        if (!res_valid_reg || res_ack) begin
          res_ones_reg  <= ones_next;
          res_zeros_reg <= zeros_next;
          res_run1_reg  <= run1_next;
          res_run0_reg  <= run0_next;
          res_sat_reg   <= sat_next;
          res_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (res_valid_reg && res_ack) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign ones_count  = ones_reg;
  assign zeros_count = zeros_reg;
  assign res_ones    = res_ones_reg;
  assign res_zeros   = res_zeros_reg;
  assign res_run1    = res_run1_reg;
  assign res_run0    = res_run0_reg;
  assign res_sat     = res_sat_reg;
  assign res_valid   = res_valid_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_lfsr_stats_counter.sv
// Directed and random stimulus for lfsr_stats_counter at 4-bit widths, checked against a
// model that recomputes period statistics from the recorded list of sampled bits.
module tb_lfsr_stats_counter;

  localparam int W     = 4;
  localparam int LIMIT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         bit_in = 1'b0;
  logic         max_tick = 1'b0;
  logic         res_ack = 1'b0;
  logic [W-1:0] ones_count;
  logic [W-1:0] zeros_count;
  logic [W-1:0] res_ones;
  logic [W-1:0] res_zeros;
  logic [W-1:0] res_run1;
  logic [W-1:0] res_run0;
  logic         res_sat;
  logic         res_valid;
  logic         overrun;

  always #5 clk = ~clk;

  lfsr_stats_counter #(
    .CNT_W(W),
    .RUN_W(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bit_in     (bit_in),
    .max_tick   (max_tick),
    .res_ack    (res_ack),
    .ones_count (ones_count),
    .zeros_count(zeros_count),
    .res_ones   (res_ones),
    .res_zeros  (res_zeros),
    .res_run1   (res_run1),
    .res_run0   (res_run0),
    .res_sat    (res_sat),
    .res_valid  (res_valid),
    .overrun    (overrun)
  );

  typedef struct {
    int ones;
    int zeros;
    int run1;
    int run0;
    bit sat;
  } stats_t;

  int     total = 0;
  int     bad = 0;
  int     nstep = 0;
  bit     period_q[$];
  stats_t m_res = '{default: 0};
  bit     m_valid = 1'b0;
  bit     m_overrun = 1'b0;

  function automatic int clip(input int v);
    return (v > LIMIT) ? LIMIT : v;
  endfunction

  // Statistics of the current period, derived from the raw list of sampled bits.
  function automatic stats_t period_stats();
    stats_t s;
    int     len;
    int     long1;
    int     long0;
    int     n1;
    int     n0;
    len = 0; long1 = 0; long0 = 0; n1 = 0; n0 = 0;
    for (int i = 0; i < period_q.size(); i++) begin
      if (period_q[i]) n1++; else n0++;
      len = (i > 0 && period_q[i] == period_q[i-1]) ? len + 1 : 1;
      if (period_q[i] && len > long1) long1 = len;
      if (!period_q[i] && len > long0) long0 = len;
    end
    s.ones  = clip(n1);
    s.zeros = clip(n0);
    s.run1  = clip(long1);
    s.run0  = clip(long0);
    s.sat   = (n1 >= LIMIT) || (n0 >= LIMIT) || (long1 >= LIMIT) || (long0 >= LIMIT);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, nstep, obs, exp);
    end
  endtask

  task automatic check_all();
    stats_t live;
    live = period_stats();
    chk("ones_count", 32'(ones_count), 32'(live.ones));
    chk("zeros_count", 32'(zeros_count), 32'(live.zeros));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_overrun));
    chk("res_ones", 32'(res_ones), 32'(m_res.ones));
    chk("res_zeros", 32'(res_zeros), 32'(m_res.zeros));
    chk("res_run1", 32'(res_run1), 32'(m_res.run1));
    chk("res_run0", 32'(res_run0), 32'(m_res.run0));
    chk("res_sat", 32'(res_sat), 32'(m_res.sat));
  endtask

  task automatic step(input bit r, input bit e, input bit b, input bit t, input bit a);
    stats_t cur;
    rst_n = r; en = e; bit_in = b; max_tick = t; res_ack = a;
    @(posedge clk);
    if (!r) begin
      period_q.delete();
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_res     = '{default: 0};
    end else begin
      if (e) period_q.push_back(b);
      if (t) begin
        cur = period_stats();
        if (!m_valid || a) begin
          m_res   = cur;
          m_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
        period_q.delete();
      end else if (m_valid && a) begin
        m_valid = 1'b0;
      end
    end
    #1;
    nstep++;
    check_all();
    $display("step %0d rst_n=%0b en=%0b bit=%0b tick=%0b ack=%0b -> ones=%0d zeros=%0d res=%0d/%0d/%0d/%0d sat=%0b valid=%0b ovr=%0b",
             nstep, r, e, b, t, a, ones_count, zeros_count, res_ones, res_zeros, res_run1, res_run0,
             res_sat, res_valid, overrun);
  endtask

  task automatic samples(input bit b, input int n);
    for (int i = 0; i < n; i++) step(1, 1, b, 0, 0);
  endtask

  initial begin
    bit r, e, b, t, a;

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    chk("reset_valid", 32'(res_valid), 32'd0);
    chk("reset_ones", 32'(ones_count), 32'd0);

    // Mixed bits with the tick carrying one more sample
    samples(1, 2); samples(0, 1); samples(1, 3);
    step(1, 1, 0, 1, 0);
    chk("mix_res_ones", 32'(res_ones), 32'd5);
    chk("mix_res_zeros", 32'(res_zeros), 32'd2);
    chk("mix_res_run1", 32'(res_run1), 32'd3);
    chk("mix_res_run0", 32'(res_run0), 32'd1);
    chk("mix_res_valid", 32'(res_valid), 32'd1);
    step(1, 0, 0, 0, 1);

    // Saturation without wrap
    samples(1, 20);
    step(1, 0, 0, 1, 0);
    chk("sat_res_ones", 32'(res_ones), 32'd15);
    chk("sat_res_run1", 32'(res_run1), 32'd15);
    chk("sat_res_sat", 32'(res_sat), 32'd1);
    step(1, 0, 0, 0, 1);

    // Two ticks without ack: second result dropped
    samples(1, 1); samples(0, 1);
    step(1, 0, 0, 1, 0);
    samples(1, 3);
    step(1, 0, 0, 1, 0);
    chk("drop_res_ones", 32'(res_ones), 32'd1);
    chk("drop_overrun", 32'(overrun), 32'd1);
    step(1, 0, 0, 0, 1);

    // Ack and tick together
    step(0, 0, 0, 0, 0);
    samples(1, 1);
    step(1, 0, 0, 1, 0);
    samples(0, 2);
    step(1, 0, 0, 1, 1);
    chk("ackt_res_zeros", 32'(res_zeros), 32'd2);
    chk("ackt_valid", 32'(res_valid), 32'd1);
    chk("ackt_overrun", 32'(overrun), 32'd0);
    step(1, 0, 0, 0, 1);

    // Mid-period reset discards the partial period
    samples(1, 4); samples(0, 3);
    step(0, 1, 1, 1, 0);
    samples(1, 3);
    step(1, 0, 0, 1, 0);
    chk("rst_res_ones", 32'(res_ones), 32'd3);
    chk("rst_res_zeros", 32'(res_zeros), 32'd0);
    chk("rst_res_sat", 32'(res_sat), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    step(1, 0, 0, 0, 1);

    // Run continues across en=0 gaps
    samples(1, 2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    samples(1, 1);
    step(1, 0, 0, 1, 0);
    chk("gap_res_run1", 32'(res_run1), 32'd3);
    step(1, 0, 0, 0, 1);

    // Random traffic with sticky bit values so long runs and saturation occur
    b = 1'b0;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(199) != 0);
      e = ($urandom_range(4) != 0);
      if ($urandom_range(3) == 0) b = ~b;
      t = ($urandom_range(14) == 0);
      a = ($urandom_range(2) == 0);
      step(r, e, b, t, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
